// File: rtl/jelly_address_generator_range_reader.sv
// Read-side address generator for a ring buffer of programmable size.
//
// Tracks how many committed words are waiting in the ring from write-commit
// notifications. Accepts a read request only when enough committed data is present.
// Each accepted request becomes one read command, or two commands when the burst
// wraps past the end of the ring.
//
// Ports:
//   reset, clk, cke     synchronous active-high reset, clock, clock enable
//   param_size          ring size in words = param_size + SIZE_OFFSET
//   s_wlen / s_wvalid   write commit (words = s_wlen + LEN_OFFSET), always accepted
//   s_len / s_valid /   read request (words = s_len + LEN_OFFSET)
//   s_ready
//   m_addr / m_len /    read command out (words = m_len + LEN_OFFSET)
//   m_valid / m_ready
//   level               committed-but-unread words
//   err_overflow        sticky flag: a commit exceeded ring capacity
module jelly_address_generator_range_reader #(
    parameter int unsigned           SIZE_WIDTH  = 32,
    parameter int unsigned           LEN_WIDTH   = 8,
    parameter int unsigned           SIZE_OFFSET = 0,
    parameter int unsigned           LEN_OFFSET  = 1,
    parameter int unsigned           ADDR_WIDTH  = SIZE_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] INIT_ADDR   = '0
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,

    input  logic [SIZE_WIDTH-1:0] param_size,

    input  logic [LEN_WIDTH-1:0]  s_wlen,
    input  logic                  s_wvalid,

    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [LEN_WIDTH-1:0]  m_len,
    output logic                  m_valid,
    input  logic                  m_ready,

    output logic [SIZE_WIDTH:0]   level,
    output logic                  err_overflow
);

    // Working width wide enough for ptr + length and level + commit without wrap.
    localparam int unsigned MAX_AL = (ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH;
    localparam int unsigned MAX_W  = (MAX_AL > SIZE_WIDTH) ? MAX_AL : SIZE_WIDTH;
    localparam int unsigned W      = MAX_W + 2;
    localparam int unsigned LVL_W  = SIZE_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] m_addr_q;
    logic [LEN_WIDTH-1:0]  m_len_q;
    logic                  m_valid_q;
    logic                  split_q;
    logic [LEN_WIDTH-1:0]  second_len_q;

    logic [W-1:0]          mem_size;
    logic [W-1:0]          rd_words;
    logic [W-1:0]          wr_words;
    logic [W-1:0]          end_addr;
    logic [W-1:0]          level_sum;
    logic                  accept;
    logic                  split;
    logic                  overflow;
    logic [LEN_WIDTH-1:0]  first_len;
    logic [LEN_WIDTH-1:0]  second_len;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [LVL_W-1:0]      level_d;

    always_comb begin
        mem_size = W'(param_size) + W'(SIZE_OFFSET);
        rd_words = W'(s_len) + W'(LEN_OFFSET);
        wr_words = W'(s_wlen) + W'(LEN_OFFSET);

        // A commit in the same cycle is deliberately not counted here.
        s_ready  = (state_q == StIdle) && (W'(level_q) >= rd_words);
        accept   = s_valid && s_ready;

        end_addr   = W'(ptr_q) + rd_words;
        split      = end_addr > mem_size;
        first_len  = LEN_WIDTH'(mem_size - W'(ptr_q) - W'(LEN_OFFSET));
        second_len = LEN_WIDTH'(W'(s_len) - W'(first_len) - W'(LEN_OFFSET));

        if (split) begin
            ptr_d = ADDR_WIDTH'(end_addr - mem_size);
        end else if (end_addr == mem_size) begin
            ptr_d = '0;
        end else begin
            ptr_d = ADDR_WIDTH'(end_addr);
        end

        // Subtraction cannot underflow: accept implies level >= rd_words.
        level_sum = W'(level_q) + (s_wvalid ? wr_words : '0) - (accept ? rd_words : '0);
        overflow  = level_sum > mem_size;
        level_d   = overflow ? LVL_W'(mem_size) : LVL_W'(level_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= INIT_ADDR;
            level_q      <= '0;
            err_q        <= 1'b0;
            m_addr_q     <= '0;
            m_len_q      <= '0;
            m_valid_q    <= 1'b0;
            split_q      <= 1'b0;
            second_len_q <= '0;
        end else if (cke) begin
            level_q <= level_d;
            if (overflow) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        m_addr_q     <= ptr_q;
                        m_len_q      <= split ? first_len : s_len;
                        m_valid_q    <= 1'b1;
                        split_q      <= split;
                        second_len_q <= second_len;
                        // Pointer advances at accept, not at command handshake.
                        ptr_q        <= ptr_d;
                        state_q      <= StFirst;
                    end
                end
                StFirst: begin
                    if (m_ready) begin
                        if (split_q) begin
                            m_addr_q <= '0;
                            m_len_q  <= second_len_q;
                            state_q  <= StSecond;
                        end else begin
                            m_valid_q <= 1'b0;
                            state_q   <= StIdle;
                        end
                    end
                end
                StSecond: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    m_valid_q <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign m_addr       = m_addr_q;
    assign m_len        = m_len_q;
    assign m_valid      = m_valid_q;
    assign level        = level_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_jelly_address_generator_range_reader.sv
module tb_jelly_address_generator_range_reader;

    logic        reset;
    logic        clk;
    logic        cke;
    logic [31:0] param_size;
    logic [7:0]  s_wlen;
    logic        s_wvalid;
    logic [7:0]  s_len;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_addr;
    logic [7:0]  m_len;
    logic        m_valid;
    logic        m_ready;
    logic [32:0] level;
    logic        err_overflow;

    jelly_address_generator_range_reader #(
        .SIZE_WIDTH  (32),
        .LEN_WIDTH   (8),
        .SIZE_OFFSET (0),
        .LEN_OFFSET  (1),
        .ADDR_WIDTH  (32),
        .INIT_ADDR   (32'd0)
    ) u_dut (
        .reset        (reset),
        .clk          (clk),
        .cke          (cke),
        .param_size   (param_size),
        .s_wlen       (s_wlen),
        .s_wvalid     (s_wvalid),
        .s_len        (s_len),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_addr       (m_addr),
        .m_len        (m_len),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .level        (level),
        .err_overflow (err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        cke;
        logic        wv;
        logic [7:0]  wlen;
        logic        sv;
        logic [7:0]  slen;
        logic        mr;
        logic        exp_rdy;
        logic        exp_mv;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        logic [32:0] exp_level;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic c, input logic wv, input int wlen, input logic sv,
                               input int slen, input logic mr, input logic rdy, input logic mv,
                               input int addr, input int len, input int lvl, input logic err);
        vec_t r;
        r.cke = c;       r.wv = wv;       r.wlen = 8'(wlen);
        r.sv = sv;       r.slen = 8'(slen); r.mr = mr;
        r.exp_rdy = rdy; r.exp_mv = mv;   r.exp_addr = 32'(addr);
        r.exp_len = 8'(len); r.exp_level = 33'(lvl); r.exp_err = err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic wv, input logic [7:0] wlen, input logic sv,
                         input logic [7:0] slen, input logic mr);
        cke = c; s_wvalid = wv; s_wlen = wlen; s_valid = sv; s_len = slen; m_ready = mr;
    endtask

    // Drive, check s_ready before the edge, then check registered outputs after it.
    task automatic apply(input vec_t t, input string tag);
        drive(t.cke, t.wv, t.wlen, t.sv, t.slen, t.mr);
        #1;
        chk({tag, " s_ready"}, 64'(s_ready), 64'(t.exp_rdy));
        @(posedge clk);
        #1;
        chk({tag, " m_valid"}, 64'(m_valid), 64'(t.exp_mv));
        if (t.exp_mv) begin
            chk({tag, " m_addr"}, 64'(m_addr), 64'(t.exp_addr));
            chk({tag, " m_len"}, 64'(m_len), 64'(t.exp_len));
        end
        chk({tag, " level"}, 64'(level), 64'(t.exp_level));
        chk({tag, " err_overflow"}, 64'(err_overflow), 64'(t.exp_err));
    endtask

    initial begin
        //                 cke wv wlen sv slen mr | rdy mv addr len lvl err
        tbl.push_back(v(1, 1,  7, 1,  0, 1,  0, 0,  0,  0,  8, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  1, 1,  0,  3,  4, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  0, 0,  0,  0,  4, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  1, 1,  4,  3,  0, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  0, 0,  0,  0,  0, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  0, 0,  0,  0,  0, 0)); // third request blocked
        tbl.push_back(v(1, 1, 15, 0,  3, 1,  0, 0,  0,  0, 16, 0)); // full, no overflow
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  1, 1,  8,  3, 12, 0));
        tbl.push_back(v(1, 0,  0, 0,  3, 1,  0, 0,  0,  0, 12, 0));
        tbl.push_back(v(1, 0,  0, 1,  7, 1,  1, 1, 12,  3,  4, 0)); // split, first half
        tbl.push_back(v(1, 0,  0, 1,  7, 1,  0, 1,  0,  3,  4, 0)); // second half
        tbl.push_back(v(1, 0,  0, 0,  7, 1,  0, 0,  0,  0,  4, 0));
        tbl.push_back(v(1, 1,  7, 0,  7, 1,  0, 0,  0,  0, 12, 0));
        tbl.push_back(v(1, 0,  0, 1,  7, 1,  1, 1,  4,  7,  4, 0));
        tbl.push_back(v(1, 0,  0, 0,  7, 1,  0, 0,  0,  0,  4, 0));
        tbl.push_back(v(1, 0,  0, 1,  3, 1,  1, 1, 12,  3,  0, 0)); // ends exactly at ring end
        tbl.push_back(v(1, 0,  0, 0,  3, 1,  0, 0,  0,  0,  0, 0)); // no second command
        tbl.push_back(v(1, 0,  0, 0,  3, 1,  0, 0,  0,  0,  0, 0));
        tbl.push_back(v(1, 1, 15, 0, 11, 1,  0, 0,  0,  0, 16, 0));
        tbl.push_back(v(1, 0,  0, 1, 11, 1,  1, 1,  0, 11,  4, 0)); // ptr wrapped to 0
        tbl.push_back(v(1, 0,  0, 0, 11, 1,  0, 0,  0,  0,  4, 0));
        tbl.push_back(v(1, 1,  3, 0,  7, 1,  0, 0,  0,  0,  8, 0));
        tbl.push_back(v(1, 0,  0, 1,  7, 0,  1, 1, 12,  3,  0, 0)); // split under backpressure
        for (int i = 0; i < 5; i++) begin
            tbl.push_back(v(1, 0, 0, 1, 7, 0,  0, 1, 12,  3,  0, 0)); // first half held
        end
        tbl.push_back(v(1, 0,  0, 0,  7, 1,  0, 1,  0,  3,  0, 0));
        tbl.push_back(v(1, 0,  0, 0,  7, 1,  0, 0,  0,  0,  0, 0));
        tbl.push_back(v(1, 1, 13, 0,  0, 1,  0, 0,  0,  0, 14, 0));
        tbl.push_back(v(1, 1,  3, 0,  0, 1,  1, 0,  0,  0, 16, 1)); // overflow, clamp
        tbl.push_back(v(1, 1,  0, 1,  1, 1,  1, 1,  4,  1, 15, 1)); // commit + accept together
        tbl.push_back(v(1, 0,  0, 0,  1, 1,  0, 0,  0,  0, 15, 1));
        tbl.push_back(v(0, 1,  0, 1,  0, 1,  1, 0,  0,  0, 15, 1)); // cke=0 holds state

        param_size = 32'd16;
        reset = 1'b1;
        drive(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset s_ready", 64'(s_ready), 64'd0);
        chk("reset m_valid", 64'(m_valid), 64'd0);
        chk("reset level", 64'(level), 64'd0);
        chk("reset err_overflow", 64'(err_overflow), 64'd0);

        foreach (tbl[i]) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Reset while a command is stalled: pending command dropped, pointer back to init.
        apply(v(1, 0, 0, 1, 3, 0,  1, 1, 6, 3, 11, 1), "pre_reset");
        drive(1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midburst m_valid", 64'(m_valid), 64'd0);
        chk("midburst level", 64'(level), 64'd0);
        chk("midburst err_overflow", 64'(err_overflow), 64'd0);
        apply(v(1, 1, 3, 0, 3, 1,  0, 0, 0, 0, 4, 0), "post_reset_commit");
        apply(v(1, 0, 0, 1, 3, 1,  1, 1, 0, 3, 0, 0), "post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
